// File: rtl/swizzle_dram_to_cram_pingpong_if.sv
// rtl/swizzle_dram_to_cram_pingpong_if.sv - input stream and compute-RAM write bundle for the ping-pong swizzle
// Optional `passthrough` control exists only when SWIZZLE_PASSTHROUGH_EN is defined.
interface swizzle_dram_to_cram_pingpong_if #(
  parameter int DWIDTH = 40,
  parameter int AWIDTH = 9,
  parameter int NUMW   = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DWIDTH-1:0] mem_ctrl_data_in;
  logic              flush;
  logic [DWIDTH-1:0] ram_data_out;
  logic [AWIDTH-1:0] ram_addr;
  logic              ram_we;
  logic [NUMW-1:0]   ram_num;
  logic              all_done;
`ifdef SWIZZLE_PASSTHROUGH_EN
  logic              passthrough;

  modport master (
    output in_valid, mem_ctrl_data_in, flush, passthrough,
    input  in_ready, ram_data_out, ram_addr, ram_we, ram_num, all_done
  );
  modport slave (
    input  in_valid, mem_ctrl_data_in, flush, passthrough,
    output in_ready, ram_data_out, ram_addr, ram_we, ram_num, all_done
  );
`else
  modport master (
    output in_valid, mem_ctrl_data_in, flush,
    input  in_ready, ram_data_out, ram_addr, ram_we, ram_num, all_done
  );
  modport slave (
    input  in_valid, mem_ctrl_data_in, flush,
    output in_ready, ram_data_out, ram_addr, ram_we, ram_num, all_done
  );
`endif
endinterface

// File: rtl/swizzle_dram_to_cram_pingpong.sv
// rtl/swizzle_dram_to_cram_pingpong.sv - ping-pong DWIDTH x DWIDTH transpose from memory-controller words to compute RAM
// Optional word bypass compiled in with SWIZZLE_PASSTHROUGH_EN.
module swizzle_dram_to_cram_pingpong #(
  parameter int DWIDTH         = 40,
  parameter int AWIDTH         = 9,
  parameter int RAM_NUM_WORDS  = 512,
  parameter int RAM_START_ADDR = 0,
  parameter int NUM_RAMS       = 4,
  parameter int NUMW           = 16
) (
  input  logic clk,
  input  logic reset,
  swizzle_dram_to_cram_pingpong_if.slave bus
);
  localparam int                CW         = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
  localparam logic [CW-1:0]     LAST_ROW   = CW'(DWIDTH - 1);
  localparam logic [AWIDTH-1:0] FIRST_ADDR = AWIDTH'(RAM_START_ADDR);
  localparam logic [AWIDTH-1:0] LAST_ADDR  = AWIDTH'(RAM_NUM_WORDS - 1);
  localparam logic [NUMW-1:0]   LAST_RAM   = NUMW'(NUM_RAMS - 1);

  logic [DWIDTH-1:0] r_buf  [2][DWIDTH];
  logic [DWIDTH-1:0] r_mask [2];
  logic [1:0]        r_full;
  logic              r_wr_sel;
  logic              r_rd_sel;
  logic [CW-1:0]     r_wr_cnt;
  logic [CW-1:0]     r_rd_cnt;
  logic [AWIDTH-1:0] r_addr_nxt;
  logic [NUMW-1:0]   r_num_nxt;
  logic [DWIDTH-1:0] r_data;
  logic [AWIDTH-1:0] r_addr;
  logic              r_we;
  logic [NUMW-1:0]   r_num;
  logic              r_done;

  logic              w_pt;
  logic              w_ready;
  logic              w_acc;
  logic              w_load;
  logic              w_close;
  logic              w_drain;
  logic              w_drain_end;
  logic              w_issue;
  logic [DWIDTH-1:0] w_col;

`ifdef SWIZZLE_PASSTHROUGH_EN
  logic r_pt;
  assign w_pt = r_pt;

  // Mode only changes when nothing is buffered, so a tile is never split across modes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pt <= 1'b0;
    end else if (!r_full[0] && !r_full[1] && r_wr_cnt == '0) begin
      r_pt <= bus.passthrough;
    end
  end
`else
  assign w_pt = 1'b0;
`endif

  assign w_ready     = (w_pt || !r_full[r_wr_sel]) && !reset;
  assign w_acc       = bus.in_valid && w_ready;
  assign w_load      = w_acc && !w_pt;
  assign w_close     = !w_pt && ((w_load && (r_wr_cnt == LAST_ROW || bus.flush)) ||
                                 (bus.flush && r_wr_cnt != '0));
  assign w_drain     = r_full[r_rd_sel];
  assign w_drain_end = w_drain && r_rd_cnt == LAST_ROW;
  assign w_issue     = w_pt ? w_acc : w_drain;

  // Column rd_cnt of the draining buffer; rows never written in this tile read as 0.
  always_comb begin
    w_col = '0;
    for (int j = 0; j < DWIDTH; j++) begin
      w_col[j] = r_buf[r_rd_sel][j][r_rd_cnt] & r_mask[r_rd_sel][j];
    end
  end

  always_ff @(posedge clk) begin
    if (w_load) begin
      r_buf[r_wr_sel][r_wr_cnt] <= bus.mem_ctrl_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_full     <= '0;
      r_mask[0]  <= '0;
      r_mask[1]  <= '0;
      r_wr_sel   <= 1'b0;
      r_rd_sel   <= 1'b0;
      r_wr_cnt   <= '0;
      r_rd_cnt   <= '0;
      r_addr_nxt <= FIRST_ADDR;
      r_num_nxt  <= '0;
      r_data     <= '0;
      r_addr     <= FIRST_ADDR;
      r_we       <= 1'b0;
      r_num      <= '0;
      r_done     <= 1'b0;
    end else begin
      // Load and drain always target different buffers, so their updates never collide.
      if (w_load) begin
        r_mask[r_wr_sel][r_wr_cnt] <= 1'b1;
      end
      if (w_close) begin
        r_full[r_wr_sel] <= 1'b1;
        r_wr_sel         <= ~r_wr_sel;
        r_wr_cnt         <= '0;
      end else if (w_load) begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
      end

      if (w_drain_end) begin
        r_full[r_rd_sel] <= 1'b0;
        r_mask[r_rd_sel] <= '0;
        r_rd_sel         <= ~r_rd_sel;
        r_rd_cnt         <= '0;
      end else if (w_drain) begin
        r_rd_cnt <= r_rd_cnt + 1'b1;
      end

      r_we   <= w_issue;
      r_done <= 1'b0;
      if (w_issue) begin
        r_data <= w_pt ? bus.mem_ctrl_data_in : w_col;
        r_addr <= r_addr_nxt;
        r_num  <= r_num_nxt;
        if (r_addr_nxt == LAST_ADDR) begin
          r_addr_nxt <= FIRST_ADDR;
          if (r_num_nxt == LAST_RAM) begin
            r_num_nxt <= '0;
            r_done    <= 1'b1;
          end else begin
            r_num_nxt <= r_num_nxt + 1'b1;
          end
        end else begin
          r_addr_nxt <= r_addr_nxt + 1'b1;
        end
      end
    end
  end

  assign bus.in_ready     = w_ready;
  assign bus.ram_data_out = r_data;
  assign bus.ram_addr     = r_addr;
  assign bus.ram_we       = r_we;
  assign bus.ram_num      = r_num;
  assign bus.all_done     = r_done;
endmodule

// File: tb/tb_swizzle_dram_to_cram_pingpong.sv
// tb/tb_swizzle_dram_to_cram_pingpong.sv - scoreboard bench for the ping-pong swizzle (DWIDTH=8, 2 RAMs of 16 words)
module tb_swizzle_dram_to_cram_pingpong;
  localparam int DW = 8;
  localparam int AW = 9;
  localparam int NW = 16;
  localparam int RAM_WORDS = 16;
  localparam int RAMS = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  swizzle_dram_to_cram_pingpong_if #(.DWIDTH(DW), .AWIDTH(AW), .NUMW(NW)) bus ();

  swizzle_dram_to_cram_pingpong #(
    .DWIDTH(DW), .AWIDTH(AW), .RAM_NUM_WORDS(RAM_WORDS), .RAM_START_ADDR(0),
    .NUM_RAMS(RAMS), .NUMW(NW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    logic [NW-1:0] n;
    logic          done;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int run = 0;
  int max_run = 0;
  int done_cnt = 0;

  logic [DW-1:0] m_rows [DW];
  int            m_cnt;
  logic [AW-1:0] m_addr;
  logic [NW-1:0] m_num;

  task automatic model_clear();
    for (int j = 0; j < DW; j++) m_rows[j] = '0;
    m_cnt  = 0;
    m_addr = '0;
    m_num  = '0;
  endtask

  task automatic model_close();
    exp_t e;
    for (int k = 0; k < DW; k++) begin
      for (int j = 0; j < DW; j++) e.d[j] = m_rows[j][k];
      e.a    = m_addr;
      e.n    = m_num;
      e.done = (m_addr == AW'(RAM_WORDS - 1)) && (m_num == NW'(RAMS - 1));
      q.push_back(e);
      if (m_addr == AW'(RAM_WORDS - 1)) begin
        m_addr = '0;
        m_num  = (m_num == NW'(RAMS - 1)) ? '0 : m_num + 1'b1;
      end else begin
        m_addr = m_addr + 1'b1;
      end
    end
    for (int j = 0; j < DW; j++) m_rows[j] = '0;
    m_cnt = 0;
  endtask

  // Scoreboard consumer: every RAM write must match the oldest expected word.
  always @(negedge clk) begin
    if (bus.ram_we === 1'b1) begin
      exp_t e;
      run++;
      if (run > max_run) max_run = run;
      if (bus.all_done === 1'b1) done_cnt++;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write data=%h addr=%0d num=%0d required=no write", bus.ram_data_out, bus.ram_addr, bus.ram_num);
      end else begin
        e = q.pop_front();
        if (bus.ram_data_out !== e.d) begin
          bad++;
          $display("FAIL ram_data_out got=%h want=%h", bus.ram_data_out, e.d);
        end
        total++;
        if (bus.ram_addr !== e.a) begin
          bad++;
          $display("FAIL ram_addr got=%0d want=%0d", bus.ram_addr, e.a);
        end
        total++;
        if (bus.ram_num !== e.n) begin
          bad++;
          $display("FAIL ram_num got=%0d want=%0d", bus.ram_num, e.n);
        end
        total++;
        if (bus.all_done !== e.done) begin
          bad++;
          $display("FAIL all_done got=%b want=%b", bus.all_done, e.done);
        end
      end
    end else begin
      run = 0;
      total++;
      if (bus.all_done !== 1'b0) begin
        bad++;
        $display("FAIL all_done_idle got=%b want=0", bus.all_done);
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic fl);
    int g = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.mem_ctrl_data_in = d;
    bus.flush = fl;
    while (bus.in_ready !== 1'b1 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (bus.in_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL accept_timeout in_ready=%b required=1", bus.in_ready);
    end else begin
      m_rows[m_cnt] = d;
      m_cnt++;
      if (m_cnt == DW || fl) model_close();
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
  endtask

  task automatic do_flush();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.flush = 1'b1;
    if (m_cnt > 0) model_close();
    @(negedge clk);
    bus.flush = 1'b0;
  endtask

  task automatic wait_drain();
    int g = 0;
    while (q.size() != 0 && g < 300) begin
      @(negedge clk);
      g++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout pending=%0d required=0", q.size());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic hit_reset();
    @(negedge clk);
    #1;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    q.delete();
    model_clear();
  endtask

  task automatic test_reset();
    hit_reset();
    repeat (2) @(negedge clk);
    total++;
    if (bus.ram_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b want=0", bus.ram_we); end
    total++;
    if (bus.ram_addr !== '0) begin bad++; $display("FAIL rst_addr got=%0d want=0", bus.ram_addr); end
    total++;
    if (bus.ram_num !== '0) begin bad++; $display("FAIL rst_num got=%0d want=0", bus.ram_num); end
    total++;
    if (bus.ram_data_out !== '0) begin bad++; $display("FAIL rst_data got=%h want=0", bus.ram_data_out); end
    total++;
    if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_in_reset got=%b want=0", bus.in_ready); end
    #1;
    reset = 1'b0;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after got=%b want=1", bus.in_ready); end
  endtask

  task automatic test_single();
    for (int j = 0; j < DW; j++) send(DW'(1) << j, 1'b0);
    idle();
    total++;
    if (bus.ram_we !== 1'b0) begin bad++; $display("FAIL latency_early got=%b want=0", bus.ram_we); end
    @(negedge clk);
    total++;
    if (bus.ram_we !== 1'b1) begin bad++; $display("FAIL latency_first got=%b want=1", bus.ram_we); end
    wait_drain();
  endtask

  task automatic test_row0();
    send(8'hFF, 1'b0);
    for (int j = 1; j < DW; j++) send(8'h00, 1'b0);
    idle();
    wait_drain();
  endtask

  task automatic test_flush();
    for (int j = 0; j < 3; j++) send(8'hFF, 1'b0);
    idle();
    do_flush();
    wait_drain();
    do_flush();
    repeat (12) @(negedge clk);
    send(8'h81, 1'b0);
    send(8'h42, 1'b0);
    send(8'h24, 1'b1);
    idle();
    wait_drain();
    for (int j = 0; j < DW; j++) send(DW'(j * 37 + 5), 1'b0);
    idle();
    wait_drain();
  endtask

  task automatic test_back_to_back();
    max_run = 0;
    for (int j = 0; j < 3 * DW; j++) send(DW'($urandom), 1'b0);
    idle();
    wait_drain();
    total++;
    if (max_run != 3 * DW) begin bad++; $display("FAIL b2b_we_run got=%0d want=%0d", max_run, 3 * DW); end
  endtask

  task automatic test_wrap();
    hit_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    done_cnt = 0;
    for (int j = 0; j < RAM_WORDS * RAMS; j++) send(DW'($urandom), 1'b0);
    idle();
    wait_drain();
    total++;
    if (done_cnt != 1) begin bad++; $display("FAIL all_done_count got=%0d want=1", done_cnt); end
    for (int j = 0; j < DW; j++) send(DW'($urandom), 1'b0);
    idle();
    wait_drain();
  endtask

  task automatic test_reset_mid();
    for (int j = 0; j < DW; j++) send(DW'(8'hA5 ^ j), 1'b0);
    idle();
    repeat (3) @(negedge clk);
    hit_reset();
    @(negedge clk);
    total++;
    if (bus.ram_we !== 1'b0) begin bad++; $display("FAIL mid_rst_we got=%b want=0", bus.ram_we); end
    total++;
    if (bus.ram_addr !== '0) begin bad++; $display("FAIL mid_rst_addr got=%0d want=0", bus.ram_addr); end
    total++;
    if (bus.ram_num !== '0) begin bad++; $display("FAIL mid_rst_num got=%0d want=0", bus.ram_num); end
    #1;
    reset = 1'b0;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready got=%b want=1", bus.in_ready); end
    repeat (15) @(negedge clk);
    for (int j = 0; j < DW; j++) send(DW'(8'h3C + j), 1'b0);
    idle();
    wait_drain();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.mem_ctrl_data_in = '0;
    bus.flush = 1'b0;
`ifdef SWIZZLE_PASSTHROUGH_EN
    bus.passthrough = 1'b0;
`endif
    model_clear();
    test_reset();
    test_single();
    test_row0();
    test_flush();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout reached required=finish earlier");
    $fatal(1, "timeout");
  end
endmodule
